// File: rtl/dffn_univ.sv
`default_nettype none
// ============================================================================
//  Module      : dffn_univ
//  Description : Universal register. Supports hold, parallel load, shift
//                left/right, rotate left/right, increment and clear. There
//                is a registered shift-out bit (SO) and a registered
//                increment-wrap pulse (CO). Reset is synchronous and
//                active-high.
//  Revision    : 1.0 - initial release
// ============================================================================
module dffn_univ #(
    parameter int          WIDTH     = 4,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             CO
);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_LOAD = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_SHR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_ROR  = 3'b101;
    localparam logic [2:0] c_MODE_INC  = 3'b110;
    localparam logic [2:0] c_MODE_CLR  = 3'b111;

    // RESET_VAL is truncated to the register width.
    localparam logic [WIDTH-1:0] c_RESET_Q = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             so_q;
    logic             so_d;
    logic             co_q;
    logic             co_d;

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic             w_msb;

    // A 1-bit register has no inner bits. Shifts collapse to loading SI,
    // and rotates collapse to holding the value.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shl = SI;
            assign w_shr = SI;
            assign w_rol = q_q;
            assign w_ror = q_q;
        end else begin : g_wn
            assign w_shl = {q_q[WIDTH-2:0], SI};
            assign w_shr = {SI, q_q[WIDTH-1:1]};
            assign w_rol = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            assign w_ror = {q_q[0], q_q[WIDTH-1:1]};
        end
    endgenerate

    assign w_msb = q_q[WIDTH-1];

    // Next-state selection. Inputs D and SI are only routed through the
    // modes that read them, so unknowns on them cannot reach Q otherwise.
    always_comb begin
        q_d  = q_q;
        so_d = so_q;
        co_d = 1'b0;
        if (E) begin
            case (mode)
                c_MODE_HOLD: q_d = q_q;
                c_MODE_LOAD: q_d = D;
                c_MODE_SHL: begin
                    q_d  = w_shl;
                    so_d = w_msb;
                end
                c_MODE_SHR: begin
                    q_d  = w_shr;
                    so_d = q_q[0];
                end
                c_MODE_ROL: begin
                    q_d  = w_rol;
                    so_d = w_msb;
                end
                c_MODE_ROR: begin
                    q_d  = w_ror;
                    so_d = q_q[0];
                end
                c_MODE_INC: begin
                    q_d  = q_q + c_ONE;
                    co_d = &q_q;
                end
                c_MODE_CLR: q_d = '0;
                default:    q_d = q_q;
            endcase
        end
    end

    // State register. Reset overrides any operation, including a wrapping increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q  <= c_RESET_Q;
            so_q <= 1'b0;
            co_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            so_q <= so_d;
            co_q <= co_d;
        end
    end

    assign Q  = q_q;
    assign SO = so_q;
    assign CO = co_q;

endmodule
`default_nettype wire

// File: doc/dffn_univ.md
DFFN_UNIV -- requirements
Module: dffn_univ

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, which sets the register width in bits; legal values are 1 to 32.
REQ-002 The module SHALL have parameter RESET_VAL, default 0, which is the value loaded into Q on reset, truncated to WIDTH bits.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: reset is synchronous and active-high.
REQ-005 Port E SHALL be an input, 1 bit wide: enable; the operation selected by mode executes only when E=1.
REQ-006 Port mode SHALL be an input, 3 bits wide: the operation select.
REQ-007 Port D SHALL be an input, WIDTH bits wide: the parallel load data.
REQ-008 Port SI SHALL be an input, 1 bit wide: the serial input bit for shift operations.
REQ-009 Port Q SHALL be an output, WIDTH bits wide: the registered state.
REQ-010 Port SO SHALL be an output, 1 bit wide: a registered copy of the last bit shifted or rotated out of Q.
REQ-011 Port CO SHALL be an output, 1 bit wide: a registered one-cycle pulse that marks an increment wrap.

Function
REQ-012 Q, SO and CO SHALL change only on the rising edge of clk; there SHALL be no combinational path from inputs to outputs.
REQ-013 With E=0 and reset=0, Q and SO SHALL hold their values and CO SHALL be 0 on the next edge, for any mode.
REQ-014 With E=1, mode SHALL select the operation as follows:
- 000 hold: Q keeps its value.
- 001 load: Q <= D.
- 010 shift left: Q <= {Q[W-2:0], SI}.
- 011 shift right: Q <= {SI, Q[W-1:1]}.
- 100 rotate left: Q <= {Q[W-2:0], Q[W-1]}.
- 101 rotate right: Q <= {Q[0], Q[W-1:1]}.
- 110 increment: Q <= Q+1, modulo 2^WIDTH.
- 111 clear: Q <= 0, not RESET_VAL.
REQ-015 SO SHALL take Q[W-1] (the pre-edge value) on shift left and rotate left, and Q[0] on shift right and rotate right; in every other mode SO SHALL hold.
REQ-016 CO SHALL be 1 for exactly the cycle after an increment in which the pre-edge Q was all ones, so that Q wraps to 0; in every other case CO SHALL be 0.
REQ-017 Consecutive wrapping increments SHALL produce a separate CO pulse for each wrap.
REQ-018 For WIDTH=1:
- shift left and shift right SHALL both give Q <= SI.
- rotate left and rotate right SHALL leave Q unchanged.
- SO SHALL take the pre-edge Q[0].
REQ-019 Shift and rotate SHALL be lossless apart from the bit that exits: WIDTH successive rotates in the same direction SHALL restore the original Q.
REQ-020 An X or Z on D or SI SHALL NOT affect Q in any mode that does not read that input.

Reset
REQ-021 When reset=1 at a rising edge, the module SHALL set Q <= RESET_VAL, SO <= 0 and CO <= 0, regardless of E, mode, D and SI.
REQ-022 Reset SHALL take priority over every operation, including one in progress: an increment in the same cycle as reset SHALL NOT generate a CO pulse.
REQ-023 Before the first reset edge, the output values SHALL be undefined; the bench SHALL assert reset for at least one edge before it checks any output.
REQ-024 The first operation after reset deasserts SHALL execute on the first edge at which reset=0 and E=1.

Verification (WIDTH=4, RESET_VAL=4'b1010 unless stated)
REQ-025 Reset and enable: reset=1 for 1 edge -> Q=1010, SO=0, CO=0; then E=0, mode=001, D=0101 for 3 edges -> Q stays 1010.
REQ-026 Load and clear: E=1, mode=001, D=0110 -> Q=0110; then mode=111 -> Q=0000; then reset -> Q=1010.
REQ-027 Shift: from Q=1001, mode=010, SI=1 -> Q=0011, SO=1; then mode=011, SI=0 -> Q=0001, SO=1.
REQ-028 Rotate: from Q=1000, 4 edges of mode=100 -> Q goes 0001, 0010, 0100, 1000; SO goes 1, 0, 0, 0.
REQ-029 Increment wrap: from Q=1110, 3 edges of mode=110 -> Q goes 1111, 0000, 0001; CO is 0, 1, 0; reset in the same cycle as the 1111 to 0000 increment -> Q=1010, CO=0.
REQ-030 WIDTH=1 instance: mode=010, SI=1 -> Q=1, SO = previous Q; then mode=100 -> Q unchanged.
